// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the SPI responder and its matching master.
//   SPI_DATA_W          default word width, MSB first
//   spi_state_t         frame state: IDLE (cs high) / ACTIVE (cs low)
//   spi_mode_t          clock mode: cpol (sclk idle level), cpha (sample edge)
//   spi_sample_on_rise  tells whether a mode samples mosi on the rising sclk edge
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic {
        SPI_IDLE,
        SPI_ACTIVE
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // The leading edge rises when cpol=0. cpha=0 samples on the leading edge and
    // cpha=1 on the trailing edge. So sampling is on the rising edge exactly when
    // cpol == cpha: modes 0 and 3 sample on rise, modes 1 and 2 sample on fall.
    function automatic logic spi_sample_on_rise(spi_mode_t mode);
        return ~(mode.cpol ^ mode.cpha);
    endfunction

endpackage

// File: rtl/spi_if.sv
// Word-level data path between the SPI responder and the internal logic.
//   tx_data/tx_valid/tx_ready  next word to send. It is accepted on valid & ready.
//   rx_data/rx_valid           received word plus a one-cycle strobe. There is no backpressure.
// Modports:
//   slave   the SPI responder side, which consumes tx and produces rx.
//   master  the internal logic side, which produces tx and consumes rx.
interface spi_if #(
    parameter int DATA_W = spi_pkg::SPI_DATA_W
);
    import spi_pkg::*;

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid
    );

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid
    );

endinterface

// File: rtl/spi_pin_sync.sv
// Synchronizer for one asynchronous SPI pin, with registered edge detection.
//   clk, rst   system clock and synchronous active-high reset
//   pin        asynchronous pin input
//   level      synchronized pin value. It is delayed by one extra flop so that it
//              lines up with the edge strobes.
//   rise/fall  one-cycle strobes that mark a level change. They assert in the
//              same cycle as the new level.
// The delay from a pin change to a strobe is SYNC_STAGES+1 clk cycles. SYNC_STAGES must be at least 2.
module spi_pin_sync
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;

    // NOTE: all state uses non-blocking assignments, so every flop in the chain
    // samples its predecessor's pre-edge value. The reset is synchronous and sits
    // inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            level  <= RST_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            level  <= sync_q[SYNC_STAGES-1];
            rise   <=  sync_q[SYNC_STAGES-1] & ~level;
            fall   <= ~sync_q[SYNC_STAGES-1] &  level;
        end
    end

endmodule

// File: rtl/spi_slave_if.sv
// SPI responder. It oversamples sclk, cs and mosi in the clk domain, shifts in
// DATA_W-bit words MSB first, and drives reply words on miso.
//   clk, rst      system clock and synchronous active-high reset
//   cpol, cpha    SPI clock mode. These must be static while cs is high.
//   sclk, cs, mosi  asynchronous SPI pins. cs is active low.
//   miso, miso_oe   reply data (the tx shift register MSB) and its output enable
//   bus (slave)     tx holding-register handshake and rx word strobe
//   tx_underrun     one-cycle pulse when a word load finds the holding register empty
//   frame_err       one-cycle pulse when cs is released in the middle of a word
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   cpol,
    input  logic   cpha,
    input  logic   sclk,
    input  logic   cs,
    input  logic   mosi,
    output logic   miso,
    output logic   miso_oe,
    spi_if.slave   bus,
    output logic   tx_underrun,
    output logic   frame_err
);

    localparam int CNT_W = $clog2(DATA_W);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .pin(sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    // The cs synchronizer resets to 0, which is the "selected" level. A frame that
    // is still in flight when reset releases therefore gives no falling edge. Only
    // a later high-then-low sequence on cs starts a new frame.
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
        .clk(clk), .rst(rst), .pin(cs),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .pin(mosi),
        .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    // The design needs only the sclk and cs edges and the mosi level. The other
    // synchronizer outputs are deliberately left unused.
    logic unused_pin_outputs;
    assign unused_pin_outputs = sclk_level ^ cs_level ^ mosi_rise ^ mosi_fall;

    spi_mode_t mode;
    logic      sample_on_rise;
    logic      sample_edge;
    logic      shift_edge;

    assign mode           = '{cpol: cpol, cpha: cpha};
    assign sample_on_rise = spi_sample_on_rise(mode);
    assign sample_edge    = sample_on_rise ? sclk_rise : sclk_fall;
    assign shift_edge     = sample_on_rise ? sclk_fall : sclk_rise;

    spi_state_t        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic              word_done;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] hold_reg;
    logic              hold_full;
    logic              load_word;

    assign rx_next     = {rx_shift[DATA_W-2:0], mosi_s};
    assign miso        = tx_shift[DATA_W-1];
    assign bus.tx_ready = ~hold_full;

    // A word moves from the holding register into the tx shifter at cs fall
    // (cpha=0 only), and at a shift edge that opens a new word. With cpha=0 that
    // is the shift edge after a completed word. With cpha=1 it is the first
    // shift edge of each word.
    // NOTE: every signal written in this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        load_word = 1'b0;
        if (state == SPI_IDLE) begin
            load_word = cs_fall & ~cpha;
        end else if (!cs_rise && shift_edge) begin
            load_word = cpha ? (bit_cnt == '0) : word_done;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SPI_IDLE;
            bit_cnt      <= '0;
            word_done    <= 1'b0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            hold_reg     <= '0;
            hold_full    <= 1'b0;
            miso_oe      <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
            tx_underrun  <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            tx_underrun  <= 1'b0;
            frame_err    <= 1'b0;

            case (state)
                SPI_IDLE: begin
                    if (cs_fall) begin
                        state     <= SPI_ACTIVE;
                        miso_oe   <= 1'b1;
                        bit_cnt   <= '0;
                        word_done <= 1'b0;
                        rx_shift  <= '0;
                    end
                end

                SPI_ACTIVE: begin
                    // When a cs release arrives in the same cycle as a sample
                    // edge, the release takes priority and the sample is dropped.
                    if (cs_rise) begin
                        state     <= SPI_IDLE;
                        miso_oe   <= 1'b0;
                        bit_cnt   <= '0;
                        word_done <= 1'b0;
                        rx_shift  <= '0;
                        frame_err <= (bit_cnt != '0);
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= rx_next;
                            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                                bus.rx_data  <= rx_next;
                                bus.rx_valid <= 1'b1;
                                bit_cnt      <= '0;
                                word_done    <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        if (shift_edge) begin
                            if (load_word) begin
                                word_done <= 1'b0;
                            end else begin
                                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                end

                default: state <= SPI_IDLE;
            endcase

            if (load_word) begin
                tx_shift    <= hold_full ? hold_reg : '0;
                tx_underrun <= ~hold_full;
                hold_full   <= 1'b0;
            end

            // A capture can coincide only with an underrun load, because
            // tx_ready is low while the holding register is full. The load has
            // already taken the empty register, and this capture refills it.
            if (bus.tx_valid && bus.tx_ready) begin
                hold_reg  <= bus.tx_data;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed self-checking bench for spi_slave_if. It contains a bit-banged SPI
// master, a tx word feeder, and pulse/word monitors. Expected values are
// hand-computed constants.
module tb_spi_slave_if;
    import spi_pkg::*;

    localparam int HALF = 6;   // sclk phase length in clk cycles

    logic clk = 1'b0;
    logic rst, cpol, cpha, sclk, cs, mosi;
    logic miso, miso_oe, tx_underrun, frame_err;

    int errors = 0;
    int checks = 0;

    spi_if #(.DATA_W(8)) bus ();

    spi_slave_if #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha),
        .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .bus(bus),
        .tx_underrun(tx_underrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Monitors count pulses and log received words, sampling at negedge.
    logic [7:0] rx_log[$];
    int  ur_cnt = 0;
    int  fe_cnt = 0;
    time rx_t = 0;
    time last_sample_t = 0;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_log.push_back(bus.rx_data);
            rx_t = $time;
        end
        if (tx_underrun) ur_cnt++;
        if (frame_err)   fe_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input logic p, input logic h);
        cpol = p;
        cpha = h;
        sclk = p;
        wait_clk(2 * HALF);
    endtask

    task automatic cs_assert();
        cs = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_release();
        cs = 1'b1;
        wait_clk(2 * HALF);
    endtask

    // Clock nbits of word (MSB first) out on mosi and capture miso at the master's sample edges.
    task automatic spi_bits(input logic [15:0] word, input int nbits, output logic [15:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = word[nbits-1-i];
                wait_clk(HALF);
                got = {got[14:0], miso};
                sclk = ~cpol;
                last_sample_t = $time;
                wait_clk(HALF);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = word[nbits-1-i];
                wait_clk(HALF);
                got = {got[14:0], miso};
                sclk = cpol;
                last_sample_t = $time;
                wait_clk(HALF);
            end
        end
        wait_clk(HALF);
    endtask

    // Offer one tx word and hold it until the holding register accepts it.
    task automatic feed(input logic [7:0] w);
        int n;
        n = 0;
        @(negedge clk);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        while (!bus.tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("feed_accept", 32'(bus.tx_ready), 32'd1);
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic do_frame(input logic [15:0] w, input int nbits, input logic [7:0] f0,
                            input logic [7:0] f1, input int nfeed, output logic [15:0] got);
        logic [15:0] g;
        fork
            begin
                cs_assert();
                spi_bits(w, nbits, g);
                cs_release();
            end
            begin
                if (nfeed > 0) feed(f0);
                if (nfeed > 1) feed(f1);
            end
        join
        got = g;
    endtask

    initial begin
        logic [15:0] got;
        int rx0, ur0, fe0;
        logic [7:0] mosi_w[3];
        mosi_w = '{8'hAA, 8'hAA, 8'hAA};

        rst = 1'b1; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        bus.tx_data = '0; bus.tx_valid = 1'b0;
        wait_clk(5);
        check("rst_miso",        32'(miso),         32'd0);
        check("rst_miso_oe",     32'(miso_oe),      32'd0);
        check("rst_tx_ready",    32'(bus.tx_ready), 32'd1);
        check("rst_rx_data",     32'(bus.rx_data),  32'd0);
        check("rst_rx_valid",    32'(bus.rx_valid), 32'd0);
        check("rst_tx_underrun", 32'(tx_underrun),  32'd0);
        check("rst_frame_err",   32'(frame_err),    32'd0);
        rst = 1'b0;
        wait_clk(2 * HALF);

        // Mode 0: receive A5 and reply 3C (miso bits 0,0,1,1,1,1,0,0).
        set_mode(1'b0, 1'b0);
        rx0 = rx_log.size(); fe0 = fe_cnt;
        do_frame(16'h00A5, 8, 8'h3C, 8'h00, 1, got);
        check("m0_rx_count", 32'(rx_log.size() - rx0), 32'd1);
        check("m0_rx_data",  32'(rx_log[rx0]),         32'hA5);
        check("m0_miso",     32'(got[7:0]),            32'h3C);
        check("m0_latency",  32'((rx_t - last_sample_t) / 10), 32'd4);
        check("m0_frame_err", 32'(fe_cnt - fe0),       32'd0);

        // Modes 1..3: receive AA and reply 55. cpha=0 reloads after the word, so it gets two words.
        for (int m = 1; m <= 3; m++) begin
            set_mode(m[1], m[0]);
            rx0 = rx_log.size(); ur0 = ur_cnt; fe0 = fe_cnt;
            do_frame({8'h00, mosi_w[m-1]}, 8, 8'h55, 8'h55, m[0] ? 1 : 2, got);
            check($sformatf("m%0d_rx_count", m), 32'(rx_log.size() - rx0), 32'd1);
            check($sformatf("m%0d_rx_data", m),  32'(rx_log[rx0]),         32'hAA);
            check($sformatf("m%0d_miso", m),     32'(got[7:0]),            32'h55);
            check($sformatf("m%0d_underrun", m), 32'(ur_cnt - ur0),        32'd0);
            check($sformatf("m%0d_frame_err", m), 32'(fe_cnt - fe0),       32'd0);
        end

        // Mode 3: two back-to-back words with cs held low.
        set_mode(1'b1, 1'b1);
        rx0 = rx_log.size(); ur0 = ur_cnt;
        do_frame(16'h1234, 16, 8'hF0, 8'h0F, 2, got);
        check("b2b_rx_count", 32'(rx_log.size() - rx0), 32'd2);
        check("b2b_rx_word0", 32'(rx_log[rx0]),         32'h12);
        check("b2b_rx_word1", 32'(rx_log[rx0+1]),       32'h34);
        check("b2b_miso",     32'(got),                 32'hF00F);
        check("b2b_underrun", 32'(ur_cnt - ur0),        32'd0);

        // Mode 1 with nothing offered: one underrun, zeros on miso, rx intact.
        set_mode(1'b0, 1'b1);
        rx0 = rx_log.size(); ur0 = ur_cnt;
        do_frame(16'h0096, 8, 8'h00, 8'h00, 0, got);
        check("ur_pulses", 32'(ur_cnt - ur0), 32'd1);
        check("ur_miso",   32'(got[7:0]),     32'h00);
        check("ur_rx_data", 32'(rx_log[rx0]), 32'h96);

        // Mode 0: cs released after 5 bits, then a clean frame.
        set_mode(1'b0, 1'b0);
        rx0 = rx_log.size(); fe0 = fe_cnt;
        cs_assert();
        spi_bits(16'h001F, 5, got);
        cs_release();
        check("fe_pulses",   32'(fe_cnt - fe0),         32'd1);
        check("fe_rx_count", 32'(rx_log.size() - rx0),  32'd0);
        check("fe_miso_oe",  32'(miso_oe),              32'd0);
        rx0 = rx_log.size(); fe0 = fe_cnt;
        do_frame(16'h00C3, 8, 8'h00, 8'h00, 0, got);
        check("fe_next_rx_count", 32'(rx_log.size() - rx0), 32'd1);
        check("fe_next_rx_data",  32'(rx_log[rx0]),         32'hC3);
        check("fe_next_frame_err", 32'(fe_cnt - fe0),       32'd0);

        // Mode 0: reset at bit 3 of a frame. 77<<3 = B8 puts a 1 on miso beforehand.
        feed(8'h77);
        cs_assert();
        spi_bits(16'h0004, 3, got);
        feed(8'h11);
        check("pre_rst_miso_oe",  32'(miso_oe),      32'd1);
        check("pre_rst_miso",     32'(miso),         32'd1);
        check("pre_rst_tx_ready", 32'(bus.tx_ready), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("mid_rst_miso",        32'(miso),         32'd0);
        check("mid_rst_miso_oe",     32'(miso_oe),      32'd0);
        check("mid_rst_tx_ready",    32'(bus.tx_ready), 32'd1);
        check("mid_rst_rx_data",     32'(bus.rx_data),  32'd0);
        check("mid_rst_rx_valid",    32'(bus.rx_valid), 32'd0);
        check("mid_rst_tx_underrun", 32'(tx_underrun),  32'd0);
        check("mid_rst_frame_err",   32'(frame_err),    32'd0);
        rst = 1'b0;
        rx0 = rx_log.size(); fe0 = fe_cnt;
        spi_bits(16'h001F, 5, got);
        check("post_rst_oe_low", 32'(miso_oe), 32'd0);
        cs_release();
        check("post_rst_rx_count",  32'(rx_log.size() - rx0), 32'd0);
        check("post_rst_frame_err", 32'(fe_cnt - fe0),        32'd0);
        rx0 = rx_log.size();
        do_frame(16'h0081, 8, 8'h5A, 8'h00, 1, got);
        check("post_rst_rx_data", 32'(rx_log[rx0]), 32'h81);
        check("post_rst_miso",    32'(got[7:0]),    32'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
